// File: rtl/write_back_stage.sv
// Write-back stage: forms the register-file write value, queues it in a DEPTH-entry
// buffer and drains it under valid/ready. Optional macro WB_FORWARD_EN adds a forwarding lookup.
module write_back_stage #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           ans_alu,
    input  logic [WIDTH-1:0]           ans_dm,
    input  logic                       sel_mem,
    input  logic [1:0]                 load_size,
    input  logic                       load_signed,
    input  logic [REG_ADDR_W-1:0]      rd_addr,
    input  logic                       rd_we,
    output logic                       wb_valid,
    input  logic                       rf_ready,
    output logic [WIDTH-1:0]           ans_wb,
    output logic [REG_ADDR_W-1:0]      wb_addr,
    output logic                       wb_we,
`ifdef WB_FORWARD_EN
    input  logic [REG_ADDR_W-1:0]      fwd_addr,
    output logic                       fwd_hit,
    output logic [WIDTH-1:0]           fwd_data,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]      data_q [DEPTH];
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]      we_q;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] byte_ext, half_ext, mem_data, wr_data;
    logic             wr_we;
    logic             enq, deq;

    // Sub-word extension: fill with the sign (or zero), then overlay the low bits.
    always_comb begin
        byte_ext       = {WIDTH{load_signed & ans_dm[7]}};
        byte_ext[7:0]  = ans_dm[7:0];
        half_ext       = {WIDTH{load_signed & ans_dm[15]}};
        half_ext[15:0] = ans_dm[15:0];
        case (load_size)
            2'b01:   mem_data = half_ext;
            2'b10:   mem_data = byte_ext;
            default: mem_data = ans_dm;
        endcase
        wr_data = sel_mem ? mem_data : ans_alu;
        // r0 is hard-wired; keep the entry for ordering but never write it.
        wr_we   = rd_we && (rd_addr != '0);
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; ready never depends on valid in the same cycle, and the producer holds its
    // data while ready is low.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign wb_valid = (count_q != '0);
    assign enq      = in_valid && in_ready;
    assign deq      = wb_valid && rf_ready;

    assign ans_wb  = wb_valid ? data_q[rd_ptr_q] : '0;
    assign wb_addr = wb_valid ? addr_q[rd_ptr_q] : '0;
    assign wb_we   = wb_valid && we_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Flush drops everything in flight, including this cycle's transfers.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q <= '0;
        end else if (enq && !flush) begin
            data_q[wr_ptr_q] <= wr_data;
            addr_q[wr_ptr_q] <= rd_addr;
            we_q[wr_ptr_q]   <= wr_we;
        end
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && we_q[fwd_idx] &&
                (addr_q[fwd_idx] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage (WIDTH=16, REG_ADDR_W=3, DEPTH=2).
// Define WB_FORWARD_EN for both files to include the forwarding scenario.
module tb_write_back_stage;

    logic        clk;
    logic        reset, flush, in_valid, in_ready;
    logic [15:0] ans_alu, ans_dm;
    logic        sel_mem;
    logic [1:0]  load_size;
    logic        load_signed;
    logic [2:0]  rd_addr;
    logic        rd_we;
    logic        wb_valid, rf_ready;
    logic [15:0] ans_wb;
    logic [2:0]  wb_addr;
    logic        wb_we;
    logic [1:0]  count;
`ifdef WB_FORWARD_EN
    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [19:0] exp_q[$];

    write_back_stage #(.WIDTH(16), .REG_ADDR_W(3), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ans_alu(ans_alu), .ans_dm(ans_dm), .sel_mem(sel_mem),
        .load_size(load_size), .load_signed(load_signed),
        .rd_addr(rd_addr), .rd_we(rd_we),
        .wb_valid(wb_valid), .rf_ready(rf_ready),
        .ans_wb(ans_wb), .wb_addr(wb_addr), .wb_we(wb_we),
`ifdef WB_FORWARD_EN
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
        .count(count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_data(input logic sel, input logic [15:0] alu,
                                               input logic [15:0] dm, input logic [1:0] size,
                                               input logic sgn);
        if (!sel) return alu;
        case (size)
            2'b10:   return sgn ? {{8{dm[7]}}, dm[7:0]} : {8'h00, dm[7:0]};
            2'b01:   return dm[15:0];
            default: return dm;
        endcase
    endfunction

    // Scoreboard: push on accepted input, pop on accepted write, checked mid-cycle.
    always @(negedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            check_cnt++;
            if (count !== 2'(exp_q.size()))
                $display("FAIL occupancy: count=%0d expected=%0d", count, exp_q.size());
            else pass_cnt++;
            if (wb_valid && rf_ready) begin
                check_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_write: unexpected write data=%h addr=%0d", ans_wb, wb_addr);
                end else begin
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    if ({ans_wb, wb_addr, wb_we} !== e)
                        $display("FAIL sb_write: got data=%h addr=%0d we=%b expected data=%h addr=%0d we=%b",
                                 ans_wb, wb_addr, wb_we, e[19:4], e[3:1], e[0]);
                    else pass_cnt++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({model_data(sel_mem, ans_alu, ans_dm, load_size, load_signed),
                                 rd_addr, rd_we && (rd_addr != 3'd0)});
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [15:0] alu,
                         input logic [15:0] dm, input logic [1:0] size, input logic sgn,
                         input logic [2:0] addr, input logic we);
        in_valid = v; sel_mem = sel; ans_alu = alu; ans_dm = dm;
        load_size = size; load_signed = sgn; rd_addr = addr; rd_we = we;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        check_cnt++;
        if ({count, wb_valid, wb_we, ans_wb, wb_addr, in_ready} !== {2'd0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b1})
            $display("FAIL reset_state: count=%0d wb_valid=%b wb_we=%b ans_wb=%h wb_addr=%0d in_ready=%b expected 0/0/0/0000/0/1",
                     count, wb_valid, wb_we, ans_wb, wb_addr, in_ready);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        check_cnt++;
        if (count !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL reset_release: count=%0d in_ready=%b expected 0/1", count, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_single_word();
        rf_ready = 1'b1;
        drive(1, 0, 16'h0034, 16'h0000, 2'b00, 0, 3'd3, 1);
        tick();
        in_valid = 1'b0;
        check_cnt++;
        if ({wb_valid, ans_wb, wb_addr, wb_we} !== {1'b1, 16'h0034, 3'd3, 1'b1})
            $display("FAIL single_word: wb_valid=%b ans_wb=%h wb_addr=%0d wb_we=%b expected 1/0034/3/1",
                     wb_valid, ans_wb, wb_addr, wb_we);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (count !== 2'd0 || wb_valid !== 1'b0 || ans_wb !== 16'h0)
            $display("FAIL single_drain: count=%0d wb_valid=%b ans_wb=%h expected 0/0/0000", count, wb_valid, ans_wb);
        else pass_cnt++;
    endtask

    task automatic test_subword();
        logic [15:0] exp_v[4];
        exp_v[0] = 16'hFF81; exp_v[1] = 16'h0081; exp_v[2] = 16'h1181; exp_v[3] = 16'h8181;
        rf_ready = 1'b1;
        drive(1, 1, 16'hDEAD, 16'h1181, 2'b10, 1, 3'd1, 1);
        tick();
        drive(1, 1, 16'hDEAD, 16'h1181, 2'b10, 0, 3'd2, 1);
        check_cnt++;
        if (ans_wb !== exp_v[0]) $display("FAIL byte_signed: ans_wb=%h expected %h", ans_wb, exp_v[0]);
        else pass_cnt++;
        tick();
        drive(1, 1, 16'hDEAD, 16'h1181, 2'b01, 1, 3'd4, 1);
        check_cnt++;
        if (ans_wb !== exp_v[1]) $display("FAIL byte_unsigned: ans_wb=%h expected %h", ans_wb, exp_v[1]);
        else pass_cnt++;
        tick();
        drive(1, 1, 16'hDEAD, 16'h8181, 2'b01, 0, 3'd5, 1);
        check_cnt++;
        if (ans_wb !== exp_v[2]) $display("FAIL half_signed: ans_wb=%h expected %h", ans_wb, exp_v[2]);
        else pass_cnt++;
        tick();
        // ALU path ignores load_size/load_signed
        drive(1, 0, 16'h0080, 16'h1111, 2'b10, 1, 3'd6, 1);
        check_cnt++;
        if (ans_wb !== exp_v[3]) $display("FAIL half_unsigned: ans_wb=%h expected %h", ans_wb, exp_v[3]);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        check_cnt++;
        if (ans_wb !== 16'h0080) $display("FAIL alu_ignores_size: ans_wb=%h expected 0080", ans_wb);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_pressure();
        rf_ready = 1'b0;
        drive(1, 0, 16'h1111, 16'h0, 2'b00, 0, 3'd1, 1);
        tick();
        drive(1, 0, 16'h3331, 16'h0, 2'b00, 0, 3'd2, 1);
        tick();
        drive(1, 0, 16'h5555, 16'h0, 2'b00, 0, 3'd3, 1);
        repeat (3) begin
            check_cnt++;
            if (count !== 2'd2 || in_ready !== 1'b0 || ans_wb !== 16'h1111)
                $display("FAIL full_hold: count=%0d in_ready=%b ans_wb=%h expected 2/0/1111", count, in_ready, ans_wb);
            else pass_cnt++;
            tick();
        end
        rf_ready = 1'b1;
        tick();
        check_cnt++;
        if (ans_wb !== 16'h3331 || count !== 2'd1 || in_ready !== 1'b1)
            $display("FAIL drain_1: ans_wb=%h count=%0d in_ready=%b expected 3331/1/1", ans_wb, count, in_ready);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        check_cnt++;
        if (ans_wb !== 16'h5555 || count !== 2'd1)
            $display("FAIL drain_2: ans_wb=%h count=%0d expected 5555/1", ans_wb, count);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (count !== 2'd0) $display("FAIL drain_3: count=%0d expected 0", count);
        else pass_cnt++;
    endtask

    task automatic test_reg_zero();
        rf_ready = 1'b0;
        drive(1, 0, 16'hBEEF, 16'h0, 2'b00, 0, 3'd0, 1);
        tick();
        drive(1, 0, 16'h0F0F, 16'h0, 2'b00, 0, 3'd5, 0);
        check_cnt++;
        if ({wb_valid, wb_we, ans_wb, wb_addr} !== {1'b1, 1'b0, 16'hBEEF, 3'd0})
            $display("FAIL reg_zero: wb_valid=%b wb_we=%b ans_wb=%h wb_addr=%0d expected 1/0/BEEF/0",
                     wb_valid, wb_we, ans_wb, wb_addr);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        rf_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_flush_reset();
        for (int k = 0; k < 2; k++) begin
            rf_ready = 1'b0;
            drive(1, 0, 16'hA001 + 16'(k), 16'h0, 2'b00, 0, 3'd1, 1);
            tick();
            drive(1, 0, 16'hA101 + 16'(k), 16'h0, 2'b00, 0, 3'd2, 1);
            tick();
            // concurrent transfer requests must be discarded
            drive(1, 0, 16'hA201, 16'h0, 2'b00, 0, 3'd3, 1);
            rf_ready = 1'b1;
            if (k == 0) flush = 1'b1; else reset = 1'b1;
            tick();
            flush = 1'b0; reset = 1'b0; in_valid = 1'b0;
            check_cnt++;
            if ({count, wb_valid, in_ready, ans_wb, wb_we} !== {2'd0, 1'b0, 1'b1, 16'h0, 1'b0})
                $display("FAIL %s_mid_drain: count=%0d wb_valid=%b in_ready=%b ans_wb=%h wb_we=%b expected 0/0/1/0000/0",
                         (k == 0) ? "flush" : "reset", count, wb_valid, in_ready, ans_wb, wb_we);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        rf_ready = 1'b0;
        drive(1, 0, 16'h0000, 16'h0, 2'b00, 0, 3'd7, 1);
        tick();
        rf_ready = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            drive(1, 0, 16'(v), 16'h0, 2'b00, 0, 3'(v), 1);
            tick();
            check_cnt++;
            if (count !== 2'd1 || ans_wb !== 16'(v))
                $display("FAIL wrap_%0d: count=%0d ans_wb=%h expected 1/%h", v, count, ans_wb, 16'(v));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int guard;
        for (int c = 0; c < 400; c++) begin
            rf_ready = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
        guard = 0;
        while (count != 2'd0 && guard < 10) begin
            tick();
            guard++;
        end
        tick();
        check_cnt++;
        if (count !== 2'd0 || exp_q.size() != 0)
            $display("FAIL random_drain: count=%0d pending=%0d expected 0/0", count, exp_q.size());
        else pass_cnt++;
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        rf_ready = 1'b0;
        drive(1, 0, 16'h00AA, 16'h0, 2'b00, 0, 3'd2, 1);
        tick();
        drive(1, 0, 16'h00BB, 16'h0, 2'b00, 0, 3'd2, 1);
        tick();
        in_valid = 1'b0;
        fwd_addr = 3'd2;
        #1;
        check_cnt++;
        if (fwd_hit !== 1'b1 || fwd_data !== 16'h00BB)
            $display("FAIL fwd_youngest: hit=%b data=%h expected 1/00BB", fwd_hit, fwd_data);
        else pass_cnt++;
        fwd_addr = 3'd4;
        #1;
        check_cnt++;
        if (fwd_hit !== 1'b0) $display("FAIL fwd_miss: hit=%b expected 0", fwd_hit);
        else pass_cnt++;
        fwd_addr = 3'd0;
        #1;
        check_cnt++;
        if (fwd_hit !== 1'b0) $display("FAIL fwd_r0: hit=%b expected 0", fwd_hit);
        else pass_cnt++;
        rf_ready = 1'b1;
        repeat (3) tick();
    endtask
`endif

    initial begin
        reset = 1'b1; flush = 1'b0; rf_ready = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 2'b00, 0, 3'd0, 0);
`ifdef WB_FORWARD_EN
        fwd_addr = 3'd0;
`endif
        test_reset();
        test_single_word();
        test_subword();
        test_back_pressure();
        test_reg_zero();
        test_flush_reset();
        test_back_to_back();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
